// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core load/store port, the DMA/debug loader port and dmem.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface dmem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_adr;
   logic [DW-1:0] cpu_wd;
   logic [DW-1:0] cpu_rd;
   logic          cpu_stall;
   logic          dma_valid;
   logic          dma_we;
   logic [AW-1:0] dma_adr;
   logic [DW-1:0] dma_wd;
   logic          dma_ready;
   logic [DW-1:0] dma_rd;
   logic          mem_we;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd;

   modport slave (
      input  cpu_req, cpu_we, cpu_adr, cpu_wd,
      output cpu_rd, cpu_stall,
      input  dma_valid, dma_we, dma_adr, dma_wd,
      output dma_ready, dma_rd,
      output mem_we, mem_a, mem_wd,
      input  mem_rd
   );

   modport master (
      output cpu_req, cpu_we, cpu_adr, cpu_wd,
      input  cpu_rd, cpu_stall,
      output dma_valid, dma_we, dma_adr, dma_wd,
      input  dma_ready, dma_rd,
      input  mem_we, mem_a, mem_wd,
      output mem_rd
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: CPU has priority, DMA is guaranteed a grant
// after MAX_WAIT consecutive lost cycles. Grants, mux and read return are combinational.
module dmem_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4,
   parameter int CW       = 16
) (
   input  logic          clk,
   input  logic          reset,
   dmem_arbiter_if.slave bus,
   output logic [CW-1:0] dma_xfer_cnt
);
   localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   logic [WCW-1:0] wait_cnt_q;
   logic [WCW-1:0] wait_cnt_d;
   logic [CW-1:0]  xfer_cnt_q;
   logic [CW-1:0]  xfer_cnt_d;
   logic           wait_done_s;
   logic           grant_cpu_s;
   logic           grant_dma_s;

   // With MAX_WAIT=0 the DMA has always waited long enough.
   generate
      if (MAX_WAIT == 0) begin : g_no_wait
         assign wait_done_s = 1'b1;
      end else begin : g_wait
         localparam logic [WCW-1:0] MAX_W = WCW'(MAX_WAIT);
         assign wait_done_s = (wait_cnt_q >= MAX_W);
      end
   endgenerate

   // Grant decision from current requests and accumulated DMA wait.
   always_comb begin
      grant_cpu_s = 1'b0;
      grant_dma_s = 1'b0;
      if (reset) begin
         grant_cpu_s = 1'b0;
      end else if (bus.dma_valid && (!bus.cpu_req || wait_done_s)) begin
         grant_dma_s = 1'b1;
      end else if (bus.cpu_req) begin
         grant_cpu_s = 1'b1;
      end else begin
         grant_cpu_s = 1'b0;
      end
   end

   // Memory-port mux, zero-latency read return, stall and ready.
   always_comb begin
      bus.mem_we = 1'b0;
      bus.mem_a  = {AW{1'b0}};
      bus.mem_wd = {DW{1'b0}};
      bus.cpu_rd = {DW{1'b0}};
      bus.dma_rd = {DW{1'b0}};
      case ({grant_dma_s, grant_cpu_s})
         2'b01: begin
            bus.mem_we = bus.cpu_we;
            bus.mem_a  = bus.cpu_adr;
            bus.mem_wd = bus.cpu_wd;
            bus.cpu_rd = bus.mem_rd;
         end
         2'b10: begin
            bus.mem_we = bus.dma_we;
            bus.mem_a  = bus.dma_adr;
            bus.mem_wd = bus.dma_wd;
            bus.dma_rd = bus.mem_rd;
         end
         default: begin
            bus.mem_we = 1'b0;
         end
      endcase
      bus.cpu_stall = bus.cpu_req & ~grant_cpu_s & ~reset;
      bus.dma_ready = grant_dma_s;
   end

   // Starvation counter saturates at MAX_WAIT; a grant or a withdrawn request clears it.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      xfer_cnt_d = xfer_cnt_q;
      if (grant_dma_s) begin
         wait_cnt_d = {WCW{1'b0}};
         xfer_cnt_d = xfer_cnt_q + CW'(1'b1);
      end else if (bus.dma_valid) begin
         if (wait_done_s) begin
            wait_cnt_d = wait_cnt_q;
         end else begin
            wait_cnt_d = wait_cnt_q + WCW'(1'b1);
         end
      end else begin
         wait_cnt_d = {WCW{1'b0}};
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_q <= {WCW{1'b0}};
         xfer_cnt_q <= {CW{1'b0}};
      end else begin
         wait_cnt_q <= wait_cnt_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   assign dma_xfer_cnt = xfer_cnt_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: two arbiters (MAX_WAIT=4/CW=16 and MAX_WAIT=0/CW=4) share one stimulus
// stream; a behavioural model queues expected outputs that a negedge monitor pops and compares.
module tb_dmem_arbiter;
   typedef struct {
      logic [31:0] cpu_rd;
      logic [31:0] dma_rd;
      logic        stall;
      logic        ready;
      logic        we;
      logic [31:0] a;
      logic [31:0] wd;
      logic [15:0] cnt;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [15:0] cnt0;
   logic [3:0]  cnt1;

   dmem_arbiter_if #(.AW(32), .DW(32)) bus0 ();
   dmem_arbiter_if #(.AW(32), .DW(32)) bus1 ();

   dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4), .CW(16)) u_main (
      .clk(clk), .reset(reset), .bus(bus0), .dma_xfer_cnt(cnt0));
   dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(0), .CW(4)) u_mw0 (
      .clk(clk), .reset(reset), .bus(bus1), .dma_xfer_cnt(cnt1));

   logic [31:0] mem0 [256];
   logic [31:0] mem1 [256];
   assign bus0.mem_rd = mem0[bus0.mem_a[7:0]];
   assign bus1.mem_rd = mem1[bus1.mem_a[7:0]];
   always @(posedge clk) begin
      if (bus0.mem_we) mem0[bus0.mem_a[7:0]] <= bus0.mem_wd;
      if (bus1.mem_we) mem1[bus1.mem_a[7:0]] <= bus1.mem_wd;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic        s_reset, s_cpu_req, s_cpu_we, s_dma_valid, s_dma_we;
   logic [31:0] s_cpu_adr, s_cpu_wd, s_dma_adr, s_dma_wd;

   // reference model state: per instance wait count, transfer count and memory image
   int          lost [2];
   int          xfer [2];
   logic [31:0] rmem [2][256];
   exp_t        q0 [$];
   exp_t        q1 [$];

   logic        o_ready0, o_stall0, o_we0, o_ready1, o_stall1;
   logic [31:0] o_a0, o_cpurd0;
   logic [15:0] o_cnt0;
   logic [3:0]  o_cnt1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_push(input int k);
      exp_t e;
      int   mw;
      bit   dwin, cwin;
      mw = (k == 0) ? 4 : 0;
      e.cpu_rd = 32'd0; e.dma_rd = 32'd0; e.stall = 1'b0; e.ready = 1'b0;
      e.we = 1'b0; e.a = 32'd0; e.wd = 32'd0;
      e.cnt = 16'(xfer[k]);
      if (s_reset) begin
         lost[k] = 0;
         xfer[k] = 0;
      end else begin
         dwin = s_dma_valid && (!s_cpu_req || lost[k] >= mw);
         cwin = !dwin && s_cpu_req;
         e.stall = s_cpu_req && !cwin;
         e.ready = dwin;
         if (cwin) begin
            e.we = s_cpu_we; e.a = s_cpu_adr; e.wd = s_cpu_wd;
            e.cpu_rd = rmem[k][s_cpu_adr[7:0]];
            if (s_cpu_we) rmem[k][s_cpu_adr[7:0]] = s_cpu_wd;
         end
         if (dwin) begin
            e.we = s_dma_we; e.a = s_dma_adr; e.wd = s_dma_wd;
            e.dma_rd = rmem[k][s_dma_adr[7:0]];
            if (s_dma_we) rmem[k][s_dma_adr[7:0]] = s_dma_wd;
            xfer[k] = (xfer[k] + 1) & ((k == 0) ? 32'hFFFF : 32'hF);
            lost[k] = 0;
         end else if (s_dma_valid) begin
            lost[k] = (lost[k] + 1 > mw) ? mw : lost[k] + 1;
         end else begin
            lost[k] = 0;
         end
      end
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic cmp(input string t, input exp_t e, input logic [31:0] cpu_rd,
                      input logic [31:0] dma_rd, input logic stall, input logic ready,
                      input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [15:0] cnt);
      check({t, ".cpu_rd"}, 64'(cpu_rd), 64'(e.cpu_rd));
      check({t, ".dma_rd"}, 64'(dma_rd), 64'(e.dma_rd));
      check({t, ".cpu_stall"}, 64'(stall), 64'(e.stall));
      check({t, ".dma_ready"}, 64'(ready), 64'(e.ready));
      check({t, ".mem_we"}, 64'(we), 64'(e.we));
      check({t, ".mem_a"}, 64'(a), 64'(e.a));
      check({t, ".mem_wd"}, 64'(wd), 64'(e.wd));
      check({t, ".xfer_cnt"}, 64'(cnt), 64'(e.cnt));
   endtask

   // monitor: every cycle each DUT presents outputs; pop the matching expectation
   always @(negedge clk) begin
      exp_t e;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         cmp("main", e, bus0.cpu_rd, bus0.dma_rd, bus0.cpu_stall, bus0.dma_ready,
             bus0.mem_we, bus0.mem_a, bus0.mem_wd, cnt0);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         cmp("mw0", e, bus1.cpu_rd, bus1.dma_rd, bus1.cpu_stall, bus1.dma_ready,
             bus1.mem_we, bus1.mem_a, bus1.mem_wd, {12'h000, cnt1});
      end
   end

   task automatic drive();
      reset = s_reset;
      bus0.cpu_req = s_cpu_req; bus0.cpu_we = s_cpu_we; bus0.cpu_adr = s_cpu_adr; bus0.cpu_wd = s_cpu_wd;
      bus0.dma_valid = s_dma_valid; bus0.dma_we = s_dma_we; bus0.dma_adr = s_dma_adr; bus0.dma_wd = s_dma_wd;
      bus1.cpu_req = s_cpu_req; bus1.cpu_we = s_cpu_we; bus1.cpu_adr = s_cpu_adr; bus1.cpu_wd = s_cpu_wd;
      bus1.dma_valid = s_dma_valid; bus1.dma_we = s_dma_we; bus1.dma_adr = s_dma_adr; bus1.dma_wd = s_dma_wd;
   endtask

   task automatic step();
      drive();
      model_push(0);
      model_push(1);
      @(negedge clk);
      o_ready0 = bus0.dma_ready; o_stall0 = bus0.cpu_stall; o_we0 = bus0.mem_we;
      o_a0 = bus0.mem_a; o_cpurd0 = bus0.cpu_rd; o_cnt0 = cnt0;
      o_ready1 = bus1.dma_ready; o_stall1 = bus1.cpu_stall; o_cnt1 = cnt1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      s_reset = 1'b0; s_cpu_req = 1'b0; s_cpu_we = 1'b0; s_cpu_adr = 32'd0; s_cpu_wd = 32'd0;
      s_dma_valid = 1'b0; s_dma_we = 1'b0; s_dma_adr = 32'd0; s_dma_wd = 32'd0;
   endtask

   task automatic contend();
      s_cpu_req = 1'b1; s_cpu_we = 1'($urandom_range(0, 1));
      s_cpu_adr = 32'($urandom_range(0, 31)); s_cpu_wd = $urandom;
      s_dma_valid = 1'b1; s_dma_we = 1'($urandom_range(0, 1));
      s_dma_adr = 32'($urandom_range(0, 31)); s_dma_wd = $urandom;
   endtask

   initial begin
      logic [11:0] pat0, pat1, spat0, spat1;
      logic [4:0]  wpat;
      logic [31:0] prev_val;
      logic [15:0] prev_cnt;
      for (int i = 0; i < 256; i++) begin
         mem0[i] = 32'd0; mem1[i] = 32'd0;
         rmem[0][i] = 32'd0; rmem[1][i] = 32'd0;
      end
      lost[0] = 0; lost[1] = 0; xfer[0] = 0; xfer[1] = 0;

      // first reset cycle unscored: registers are still unknown before the first edge
      idle(); s_reset = 1'b1; drive();
      @(posedge clk); #1;
      step();
      idle();
      for (int i = 0; i < 3; i++) begin
         step();
         check("idle.mem_we", 64'(o_we0), 64'd0);
         check("idle.stall", 64'(o_stall0), 64'd0);
         check("idle.ready", 64'(o_ready0), 64'd0);
         check("idle.cnt", 64'(o_cnt0), 64'd0);
      end

      // CPU store then load of the same word
      s_cpu_req = 1'b1; s_cpu_we = 1'b1; s_cpu_adr = 32'h64; s_cpu_wd = 32'd7;
      step();
      check("store.mem_we", 64'(o_we0), 64'd1);
      check("store.mem_a", 64'(o_a0), 64'h64);
      check("store.stall", 64'(o_stall0), 64'd0);
      s_cpu_we = 1'b0; s_cpu_wd = 32'd0;
      step();
      check("load.cpu_rd", 64'(o_cpurd0), 64'd7);
      check("load.stall", 64'(o_stall0), 64'd0);

      // 12 cycles of continuous contention from a cleared wait count
      idle();
      for (int i = 0; i < 12; i++) begin
         contend();
         step();
         pat0[i] = o_ready0; spat0[i] = o_stall0;
         pat1[i] = o_ready1; spat1[i] = o_stall1;
      end
      check("contend.grant_pattern", 64'(pat0), 64'h210);
      check("contend.stall_pattern", 64'(spat0), 64'h210);
      check("mw0.grant_pattern", 64'(pat1), 64'hFFF);
      check("mw0.stall_pattern", 64'(spat1), 64'hFFF);
      idle();
      step();
      check("contend.xfer_cnt", 64'(o_cnt0), 64'd2);
      check("mw0.xfer_cnt", 64'(o_cnt1), 64'd12);

      // DMA withdraws after 3 lost cycles: wait restarts from zero
      for (int i = 0; i < 3; i++) begin
         contend();
         step();
      end
      idle(); s_cpu_req = 1'b1; s_cpu_adr = 32'h8;
      step();
      for (int i = 0; i < 5; i++) begin
         contend();
         step();
         wpat[i] = o_ready0;
      end
      check("withdraw.grant_pattern", 64'(wpat), 64'h10);

      // randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         s_reset = ($urandom_range(0, 49) == 0);
         s_cpu_req = ($urandom_range(0, 2) != 0); s_cpu_we = 1'($urandom_range(0, 1));
         s_cpu_adr = 32'($urandom_range(0, 31)); s_cpu_wd = $urandom;
         s_dma_valid = ($urandom_range(0, 2) != 0); s_dma_we = 1'($urandom_range(0, 1));
         s_dma_adr = 32'($urandom_range(0, 31)); s_dma_wd = $urandom;
         step();
      end

      // reset in a DMA-write grant cycle: no write, counter holds then clears
      idle(); step();
      prev_val = rmem[0][8'h20];
      prev_cnt = 16'(xfer[0]);
      s_dma_valid = 1'b1; s_dma_we = 1'b1; s_dma_adr = 32'h20; s_dma_wd = 32'hDEAD_BEEF;
      s_reset = 1'b1;
      step();
      check("rst.mem_we", 64'(o_we0), 64'd0);
      check("rst.ready", 64'(o_ready0), 64'd0);
      check("rst.cnt_hold", 64'(o_cnt0), 64'(prev_cnt));
      idle(); s_cpu_req = 1'b1; s_cpu_adr = 32'h20;
      step();
      check("rst.cnt_clear", 64'(o_cnt0), 64'd0);
      check("rst.no_write", 64'(o_cpurd0), 64'(prev_val));
      for (int i = 0; i < 5; i++) begin
         contend();
         step();
         wpat[i] = o_ready0;
      end
      check("rst.wait_cleared", 64'(wpat), 64'h10);

      // transfer counter wrap (CW=4 instance wraps 0xF -> 0)
      idle(); s_reset = 1'b1; step();
      idle();
      for (int i = 0; i < 15; i++) begin
         s_dma_valid = 1'b1; s_dma_adr = 32'(i);
         step();
      end
      idle(); step();
      check("wrap.cnt_max", 64'(o_cnt1), 64'hF);
      s_dma_valid = 1'b1; step();
      idle(); step();
      check("wrap.cnt_zero", 64'(o_cnt1), 64'h0);
      check("wrap.main_cnt", 64'(o_cnt0), 64'h10);

      @(posedge clk); #1;
      check("scoreboard.q0_drained", 64'(q0.size()), 64'd0);
      check("scoreboard.q1_drained", 64'(q1.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the single-cycle ARM core's load/store port (requester 0, "cpu") and a DMA/debug loader port (requester 1, "dma").
- The CPU has default priority. A saturating starvation counter guarantees the DMA a grant after MAX_WAIT consecutive lost cycles.
- Sits between the core's MemWrite/ALUResult/WriteData/ReadData signals and dmem. While the CPU is not granted, the arbiter raises a stall that the core uses to freeze PC and register writeback.

Parameters:
- AW, 32, address width of both requesters and of the memory port.
- DW, 32, data width.
- MAX_WAIT, 4, number of consecutive DMA-losing cycles after which the DMA wins a contention. Legal range 0..255; 0 means the DMA always wins a contention.
- CW, 16, width of the DMA transfer counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU memory access this cycle (load or store).
- cpu_we  in  1  CPU store (MemWrite).
- cpu_adr  in  AW  CPU address (ALUResult).
- cpu_wd  in  DW  CPU store data.
- cpu_rd  out  DW  CPU load data.
- cpu_stall  out  1  CPU request not granted this cycle.
- dma_valid  in  1  DMA request valid.
- dma_we  in  1  DMA write.
- dma_adr  in  AW  DMA address.
- dma_wd  in  DW  DMA write data.
- dma_ready  out  1  DMA request accepted this cycle.
- dma_rd  out  DW  DMA read data.
- mem_we  out  1  to dmem write enable.
- mem_a  out  AW  to dmem address.
- mem_wd  out  DW  to dmem write data.
- mem_rd  in  DW  from dmem; combinational read data.
- dma_xfer_cnt  out  CW  count of completed DMA transfers.

Behaviour:
- State registers:
  - wait_cnt, width clog2(MAX_WAIT+1), minimum 1 bit.
  - dma_xfer_cnt.
- Grant logic is combinational from the current inputs and wait_cnt. At most one of grant_cpu and grant_dma is high.
- Grant rules, while reset is low:
  - Only cpu_req high: grant_cpu.
  - Only dma_valid high: grant_dma.
  - Both high and wait_cnt >= MAX_WAIT: grant_dma.
  - Both high and wait_cnt < MAX_WAIT: grant_cpu.
  - Neither high: no grant.
- While reset is high:
  - No grants.
  - mem_we=0, dma_ready=0, cpu_stall=0.
  - cpu_rd=0, dma_rd=0.
  - mem_a=0, mem_wd=0.
- Memory mux:
  - grant_cpu: mem_we/mem_a/mem_wd = cpu_we/cpu_adr/cpu_wd.
  - grant_dma: mem_we/mem_a/mem_wd = dma_we/dma_adr/dma_wd.
  - No grant: mem_we=0, mem_a=0, mem_wd=0.
  - mem_we is never high without a grant.
- Read return:
  - cpu_rd = mem_rd when grant_cpu, else 0.
  - dma_rd = mem_rd when grant_dma, else 0.
  - Zero latency: same cycle as the grant. A write commits at the clock edge ending the grant cycle.
- Stall and ready:
  - cpu_stall = cpu_req & ~grant_cpu (while reset is low).
  - dma_ready = grant_dma.
  - A DMA transfer completes on any cycle with dma_valid & dma_ready.
  - The DMA must hold dma_we/dma_adr/dma_wd stable while dma_valid & ~dma_ready. The arbiter does not check this.
- wait_cnt update at the clock edge:
  - reset: 0.
  - grant_dma: 0.
  - dma_valid & ~grant_dma: +1, saturating at MAX_WAIT.
  - dma_valid low: 0.
- dma_xfer_cnt: reset 0; +1 on each completed DMA transfer; wraps 2^CW-1 -> 0.
- Boundary conditions:
  - The DMA withdrawing dma_valid mid-wait clears wait_cnt.
  - With MAX_WAIT=0 the DMA wins every contention.
  - Reset asserted mid-contention clears wait_cnt. No write occurs in a reset cycle.
  - A CPU request while stalled is re-presented unchanged by the core next cycle. The arbiter keeps no CPU state.
- Worst-case CPU stall is 1 cycle per DMA grant. Worst-case DMA wait is MAX_WAIT cycles.

Test Plan:
- Reset then idle → mem_we=0, cpu_stall=0, dma_ready=0, dma_xfer_cnt=0 for 3 cycles.
- CPU store only: cpu_req=1, cpu_we=1, cpu_adr=0x64, cpu_wd=7; then CPU load from 0x64 → mem_we=1, mem_a=0x64 on the store cycle; cpu_rd=7 on the load cycle; cpu_stall=0 throughout.
- Continuous contention, MAX_WAIT=4: cpu_req=1 and dma_valid=1 held high for 12 cycles → grant pattern CPU×4, DMA, CPU×4, DMA, CPU×2; cpu_stall=1 only on the DMA cycles; dma_xfer_cnt=2.
- DMA drops dma_valid after losing 3 cycles, then reasserts under contention → wait_cnt restarts at 0; the DMA waits a full 4 cycles again.
- MAX_WAIT=0 contention → DMA granted every cycle; cpu_stall=1 continuously; dma_rd tracks mem_rd.
- Synchronous reset asserted in a cycle where the DMA is granted with dma_we=1 → mem_we=0 that cycle; dma_xfer_cnt unchanged (later 0); wait_cnt=0. Separately, dma_xfer_cnt preloaded near 0xFFFF plus one more DMA transfer → counter wraps 0xFFFF→0.
